code_rle_packer: RTL and testbench
==================================

Name: code_rle_packer

Overview:
- Downstream consumer of the 4-bit output code stream produced by the control counter/FSM stage.
- Run-length encodes consecutive identical codes into {code, run} packets.
- Buffers packets in a small FIFO and drains them over a valid/ready interface to the logging/bus stage.

Parameters:
RUN_W, 4, run-length counter width; maximum run is RUN_MAX = 2^RUN_W - 1.
DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
AW, 2, FIFO address width; must equal log2(DEPTH).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_en  input  1  in_code is a valid sample this cycle
in_code  input  4  code from the upstream FSM output O
flush  input  1  close the current run and emit it
out_valid  output  1  FIFO head is valid
out_ready  input  1  consumer accepts the head this cycle
out_code  output  4  code of the head packet
out_run  output  RUN_W  run length of the head packet (1..RUN_MAX)
ovf  output  1  sticky flag: a packet was dropped because the FIFO was full
fill  output  AW+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at a clock edge) clears everything: active=0, cur_code=0, run=0, FIFO pointers and fill=0, ovf=0, out_valid=0. out_code and out_run read 0 whenever fill=0.
- Reset in the middle of a run discards that run and all FIFO contents. Nothing is emitted.

Accumulator (each cycle, flush=0):
- in_en=0: no change. A gap does not terminate a run.
- in_en=1 and active=0: cur_code<=in_code, run<=1, active<=1.
- in_en=1, active=1, in_code==cur_code, run<RUN_MAX: run<=run+1.
- in_en=1, active=1, and either in_code!=cur_code or run==RUN_MAX:
  - push {cur_code, run} to the FIFO;
  - then cur_code<=in_code, run<=1.
  - A saturated run therefore splits: RUN_MAX, then the remainder.

Flush:
- flush=1, active=1: push {cur_code, run}, then active<=0 and run<=0.
- flush=1, active=0: no-op.
- flush=1 together with in_en=1: the flush takes priority. The in_en sample is dropped. ovf is not set by this drop.
- At most one push occurs per cycle.

FIFO:
- Push is accepted if fill<DEPTH, or if a pop occurs in the same cycle (out_valid and out_ready both 1).
- Otherwise the packet is dropped and ovf<=1. ovf stays set until rst.
- Pop occurs when out_valid=1 and out_ready=1.
- Push and pop in the same cycle: fill unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- out_valid = (fill!=0). out_code and out_run come directly from the head entry (first-word fall-through).
- Latency: a push decided at edge N gives out_valid=1 and valid head data after edge N. A packet into an empty FIFO is visible in the cycle following the terminating sample.
- out_code and out_run hold stable while out_valid=1 and out_ready=0.

Width rules:
- run never exceeds RUN_MAX and never wraps to 0.
- fill is AW+1 bits wide so that the value DEPTH is representable.

Test Plan:
- Reset, out_ready=1, in_en=1 with codes 6,3,3,3,2,2, then flush=1 → packets (6,1), (3,3), (2,2) in order; ovf=0; fill returns to 0.
- 17 consecutive samples of code 4, then flush, RUN_W=4 → packets (4,15), (4,2).
- Codes 1,1,in_en=0 for 3 cycles,1,5, then flush → packets (1,3), (5,1). The gap does not split the run.
- out_ready=0, five single-sample runs 1,2,3,4,5,6 (the 6 closes the 5) → fill=4, (5,1) dropped, ovf=1. Then out_ready=1 drains (1,1),(2,1),(3,1),(4,1); ovf stays 1.
- FIFO full with out_ready=1 and a push in the same cycle → push accepted, fill stays 4, ovf=0, order preserved.
- Run of code 9 at run=3 with 2 packets queued, then rst=1 for one cycle → fill=0, out_valid=0, ovf=0. Next sample 7 then flush → only (7,1) is emitted.

Source files
------------

// File: rtl/code_rle_packer.sv
// code_rle_packer: run-length encodes a 4-bit code stream into {code, run} packets behind a small FWFT FIFO
module code_rle_packer #(
    parameter int RUN_W = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_en,
    input  logic [3:0]       in_code,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_code,
    output logic [RUN_W-1:0] out_run,
    output logic             ovf,
    output logic [AW:0]      fill
);
    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
    localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
    logic             active_q, active_d;
    logic [3:0]       cur_code_q, cur_code_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, accept;
    logic [RUN_W+3:0] mem_q [DEPTH];
    logic [RUN_W+3:0] head;
    always_comb begin
        active_d   = active_q;
        cur_code_d = cur_code_q;
        run_d      = run_q;
        push       = 1'b0;
        if (flush) begin
            push     = active_q;
            active_d = 1'b0;
            run_d    = active_q ? '0 : run_q;
        end else if (in_en) begin
            active_d   = 1'b1;
            cur_code_d = in_code;
            if (!active_q) begin
                run_d = RUN_W'(1);
            end else if (in_code == cur_code_q && run_q != RUN_MAX) begin
                run_d = run_q + RUN_W'(1);
            end else begin
                push  = 1'b1;
                run_d = RUN_W'(1);
            end
        end
        pop      = out_valid && out_ready;
        accept   = push && (fill_q != FULL || pop);
        ovf_d    = ovf_q || (push && !accept);
        wr_ptr_d = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        fill_d   = fill_q + (AW+1)'(accept) - (AW+1)'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 1'b0;
            cur_code_q <= '0;
            run_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            active_q   <= active_d;
            cur_code_q <= cur_code_d;
            run_q      <= run_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            ovf_q      <= ovf_d;
        end
    end
    // storage needs no reset: fill gates everything read from it
    always_ff @(posedge clk) begin
        if (!rst && accept) mem_q[wr_ptr_q] <= {cur_code_q, run_q};
    end
    assign head      = mem_q[rd_ptr_q];
    assign out_valid = fill_q != '0;
    assign out_code  = out_valid ? head[RUN_W+3:RUN_W] : '0;
    assign out_run   = out_valid ? head[RUN_W-1:0] : '0;
    assign ovf       = ovf_q;
    assign fill      = fill_q;
endmodule

// File: tb/tb_code_rle_packer.sv
// tb_code_rle_packer: directed checks of run-length packing, FIFO flow control and reset
module tb_code_rle_packer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_en = 1'b0;
    logic [3:0] in_code = '0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_code;
    logic [3:0] out_run;
    logic       ovf;
    logic [2:0] fill;
    int passed = 0;
    int total = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    code_rle_packer #(.RUN_W(4), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_code(in_code), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_run(out_run), .ovf(ovf), .fill(fill)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back({out_code, out_run});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic en, input logic [3:0] code, input logic fl);
        in_en = en;
        in_code = code;
        flush = fl;
        tick();
        in_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_pkts(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk(tag, (i < got.size()) ? {24'd0, got[i]} : 32'hxxxxxxxx, {24'd0, exp_q[i]});
        got.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got.delete();
    endtask

    initial begin
        idle(2);
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_fill", fill, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_code", out_code, 0);
        chk("rst_run", out_run, 0);

        out_ready = 1'b1;
        step(1, 6, 0);
        step(1, 3, 0);
        chk("lat_valid", out_valid, 1);
        chk("lat_head", {out_code, out_run}, 8'h61);
        step(1, 3, 0);
        step(1, 3, 0);
        step(1, 2, 0);
        step(1, 2, 0);
        step(0, 0, 1);
        idle(3);
        exp_q = '{8'h61, 8'h33, 8'h22};
        check_pkts("basic");
        chk("basic_ovf", ovf, 0);
        chk("basic_fill", fill, 0);

        for (int i = 0; i < 17; i++) step(1, 4, 0);
        step(0, 0, 1);
        idle(3);
        exp_q = '{8'h4f, 8'h42};
        check_pkts("sat");

        step(1, 1, 0);
        step(1, 1, 0);
        idle(3);
        step(1, 1, 0);
        step(1, 5, 0);
        step(0, 0, 1);
        idle(3);
        exp_q = '{8'h13, 8'h51};
        check_pkts("gap");

        out_ready = 1'b0;
        for (int c = 1; c <= 6; c++) step(1, 4'(c), 0);
        chk("full_fill", fill, 4);
        chk("full_ovf", ovf, 1);
        idle(2);
        chk("hold_head", {out_code, out_run}, 8'h11);
        out_ready = 1'b1;
        idle(5);
        exp_q = '{8'h11, 8'h21, 8'h31, 8'h41};
        check_pkts("drop");
        chk("drop_ovf_sticky", ovf, 1);
        chk("drop_fill", fill, 0);

        out_ready = 1'b0;
        do_reset();
        for (int c = 1; c <= 5; c++) step(1, 4'(c), 0);
        chk("pp_fill_pre", fill, 4);
        out_ready = 1'b1;
        step(1, 6, 0);
        chk("pp_fill", fill, 4);
        chk("pp_ovf", ovf, 0);
        step(0, 0, 1);
        chk("pp_fill2", fill, 4);
        idle(6);
        exp_q = '{8'h11, 8'h21, 8'h31, 8'h41, 8'h51, 8'h61};
        check_pkts("pp");
        chk("pp_ovf_end", ovf, 0);

        out_ready = 1'b0;
        step(1, 1, 0);
        step(1, 2, 0);
        step(1, 9, 0);
        step(1, 9, 0);
        step(1, 9, 0);
        chk("mid_fill", fill, 2);
        do_reset();
        chk("mr_fill", fill, 0);
        chk("mr_valid", out_valid, 0);
        chk("mr_ovf", ovf, 0);
        chk("mr_code", out_code, 0);
        out_ready = 1'b1;
        step(1, 7, 0);
        step(1, 8, 1);
        step(0, 0, 1);
        idle(3);
        exp_q = '{8'h71};
        check_pkts("mr");
        chk("mr_ovf_end", ovf, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
